bwp30p140lvt_pwr_switch: RTL and testbench



---
 rtl/bwp30p140lvt_pwr_pkg.sv | 13 +
 rtl/lvt_gate_decode.sv | 16 +
 rtl/bwp30p140lvt_pwr_switch.sv | 106 ++++++++++
 tb/tb_bwp30p140lvt_pwr_switch.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bwp30p140lvt_pwr_pkg.sv
// Shared types and default sizing for the ring-oscillator power-switch controller.
package bwp30p140lvt_pwr_pkg;

  typedef enum logic [1:0] {
    PS_OFF,
    PS_RAMP,
    PS_ON
  } pwr_state_e;

  localparam int unsigned DEF_N_SEG       = 4;
  localparam int unsigned DEF_STEP_CYCLES = 1;

endpackage

// File: rtl/lvt_gate_decode.sv
// INVD2 + AN2D2 gate function: inverted power enable gated by the stress-mode inverse.
module lvt_gate_decode (
  input  logic en_power_rosc,
  input  logic meas_stress,
  output logic sel_power_off,
  output logic gate_off,
  output logic en_chain
);

  always_comb begin
    sel_power_off = ~en_power_rosc;
    gate_off      = sel_power_off & ~meas_stress;
    en_chain      = ~meas_stress | sel_power_off;
  end

endmodule

// File: rtl/bwp30p140lvt_pwr_switch.sv
// Power-switch sequencer: segments ramp on one per STEP_CYCLES, all drop together.
module bwp30p140lvt_pwr_switch
  import bwp30p140lvt_pwr_pkg::*;
#(
  parameter int unsigned N_SEG       = DEF_N_SEG,
  parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_power_rosc,
  input  logic             meas_stress,
  output logic             sel_power_off,
  output logic             en_chain,
  output logic [N_SEG-1:0] seg_on,
  output logic             pwr_good
);

  localparam int unsigned CW = $clog2(STEP_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

  logic       en_power_rosc_r;
  logic       meas_stress_r;
  logic       gate_off_r;
  logic       req_on;
  logic       unused_gate_off;
  logic       unused_sel_r;
  logic       unused_chain_r;
  pwr_state_e state;
  logic [CW-1:0] cnt;

  // Raw-input copy drives the combinational outputs, unaffected by reset.
  lvt_gate_decode u_gate_raw (
    .en_power_rosc (en_power_rosc),
    .meas_stress   (meas_stress),
    .sel_power_off (sel_power_off),
    .gate_off      (unused_gate_off),
    .en_chain      (en_chain)
  );

  lvt_gate_decode u_gate_reg (
    .en_power_rosc (en_power_rosc_r),
    .meas_stress   (meas_stress_r),
    .sel_power_off (unused_sel_r),
    .gate_off      (gate_off_r),
    .en_chain      (unused_chain_r)
  );

  assign req_on = ~gate_off_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_power_rosc_r <= 1'b0;
      meas_stress_r   <= 1'b0;
      state           <= PS_OFF;
      cnt             <= '0;
      seg_on          <= '0;
      pwr_good        <= 1'b0;
    end else begin
      en_power_rosc_r <= en_power_rosc;
      meas_stress_r   <= meas_stress;
      unique case (state)
        PS_OFF: begin
          seg_on   <= '0;
          pwr_good <= 1'b0;
          if (req_on) begin
            state  <= PS_RAMP;
            seg_on <= N_SEG'(1);
            cnt    <= '0;
          end
        end
        PS_RAMP: begin
          if (!req_on) begin
            state    <= PS_OFF;
            seg_on   <= '0;
            pwr_good <= 1'b0;
          end else if (seg_on[N_SEG-1]) begin
            state    <= PS_ON;
            pwr_good <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            // Thermometer fill: next bit up, earlier bits held.
            seg_on <= seg_on | (seg_on << 1);
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PS_ON: begin
          if (!req_on) begin
            state    <= PS_OFF;
            seg_on   <= '0;
            pwr_good <= 1'b0;
          end else begin
            seg_on   <= '1;
            pwr_good <= 1'b1;
          end
        end
        default: begin
          state    <= PS_OFF;
          seg_on   <= '0;
          pwr_good <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bwp30p140lvt_pwr_switch.sv
// Directed bench for the default and a slow two-segment configuration of the power switch.
module tb_bwp30p140lvt_pwr_switch;

  logic       clk = 1'b0;
  logic       rst_a, en_a, ms_a;
  logic       rst_b, en_b, ms_b;
  logic       sel_a, chain_a, pg_a;
  logic       sel_b, chain_b, pg_b;
  logic [3:0] seg_a;
  logic [1:0] seg_b;

  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  bwp30p140lvt_pwr_switch u_dut_a (
    .clk           (clk),
    .rst           (rst_a),
    .en_power_rosc (en_a),
    .meas_stress   (ms_a),
    .sel_power_off (sel_a),
    .en_chain      (chain_a),
    .seg_on        (seg_a),
    .pwr_good      (pg_a)
  );

  bwp30p140lvt_pwr_switch #(
    .N_SEG       (2),
    .STEP_CYCLES (3)
  ) u_dut_b (
    .clk           (clk),
    .rst           (rst_b),
    .en_power_rosc (en_b),
    .meas_stress   (ms_b),
    .sel_power_off (sel_b),
    .en_chain      (chain_b),
    .seg_on        (seg_b),
    .pwr_good      (pg_b)
  );

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One cycle on DUT A: drive, check gates, queue expected state after the edge.
  task automatic cyc_a(input logic r, input logic e, input logic m, input logic [3:0] xs,
                       input logic xp, input string tag);
    logic [4:0] x;
    @(negedge clk);
    rst_a = r; en_a = e; ms_a = m;
    #1;
    chk({tag, "_sel"}, {4'b0, sel_a}, {4'b0, ~e});
    chk({tag, "_chain"}, {4'b0, chain_a}, {4'b0, ~m | ~e});
    exp_q.push_back({xs, xp});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      x = exp_q.pop_front();
      chk(tag, {seg_a, pg_a}, x);
    end
  endtask

  task automatic cyc_b(input logic r, input logic e, input logic m, input logic [1:0] xs,
                       input logic xp, input string tag);
    logic [4:0] x;
    @(negedge clk);
    rst_b = r; en_b = e; ms_b = m;
    #1;
    chk({tag, "_sel"}, {4'b0, sel_b}, {4'b0, ~e});
    chk({tag, "_chain"}, {4'b0, chain_b}, {4'b0, ~m | ~e});
    exp_q.push_back({2'b00, xs, xp});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      x = exp_q.pop_front();
      chk(tag, {2'b00, seg_b, pg_b}, x);
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; ms_a = 1'b0;
    rst_b = 1'b1; en_b = 1'b0; ms_b = 1'b0;

    // Reset then idle
    cyc_a(1, 0, 0, 4'b0000, 0, "rst0");
    cyc_a(1, 0, 0, 4'b0000, 0, "rst1");
    cyc_a(0, 0, 0, 4'b0000, 0, "idle");
    // Default ramp: en sampled at T
    cyc_a(0, 1, 0, 4'b0000, 0, "rampT");
    cyc_a(0, 1, 0, 4'b0001, 0, "ramp1");
    cyc_a(0, 1, 0, 4'b0011, 0, "ramp2");
    cyc_a(0, 1, 0, 4'b0111, 0, "ramp3");
    cyc_a(0, 1, 0, 4'b1111, 0, "ramp4");
    cyc_a(0, 1, 0, 4'b1111, 1, "ramp5");
    // Stress keeps the rail up
    cyc_a(0, 0, 1, 4'b1111, 1, "stress0");
    cyc_a(0, 0, 1, 4'b1111, 1, "stress1");
    // Turn-off latency
    cyc_a(0, 0, 0, 4'b1111, 1, "offT");
    cyc_a(0, 0, 0, 4'b0000, 0, "off1");
    // Abort mid-ramp
    cyc_a(0, 1, 0, 4'b0000, 0, "abT");
    cyc_a(0, 1, 0, 4'b0001, 0, "ab1");
    cyc_a(0, 0, 0, 4'b0011, 0, "ab2");
    cyc_a(0, 0, 0, 4'b0000, 0, "ab3");
    cyc_a(0, 1, 0, 4'b0000, 0, "reT");
    cyc_a(0, 1, 0, 4'b0001, 0, "re1");
    cyc_a(0, 1, 0, 4'b0011, 0, "re2");
    // Reset mid-ramp, rst wins over req_on
    cyc_a(1, 1, 0, 4'b0000, 0, "rmid");
    cyc_a(0, 1, 0, 4'b0000, 0, "rmidT");
    cyc_a(0, 1, 0, 4'b0001, 0, "rmid1");
    cyc_a(0, 1, 0, 4'b0011, 0, "rmid2");
    cyc_a(0, 1, 0, 4'b0111, 0, "rmid3");
    cyc_a(0, 1, 0, 4'b1111, 0, "rmid4");
    cyc_a(0, 1, 0, 4'b1111, 1, "rmid5");

    // STEP_CYCLES=3, N_SEG=2, request driven by stress mode
    cyc_b(1, 0, 0, 2'b00, 0, "b_rst");
    cyc_b(0, 0, 0, 2'b00, 0, "b_idle");
    cyc_b(0, 0, 1, 2'b00, 0, "b_T");
    cyc_b(0, 0, 1, 2'b01, 0, "b_1");
    cyc_b(0, 0, 1, 2'b01, 0, "b_2");
    cyc_b(0, 0, 1, 2'b01, 0, "b_3");
    cyc_b(0, 0, 1, 2'b11, 0, "b_4");
    cyc_b(0, 0, 1, 2'b11, 1, "b_5");
    cyc_b(0, 0, 0, 2'b11, 1, "b_offT");
    cyc_b(0, 0, 0, 2'b00, 0, "b_off1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
